// File: rtl/microcode_sequencer_if.sv
// Control-store handshake between the microcode sequencer and the datapath/ROM side.
interface microcode_sequencer_if #(parameter int CNT_W = 32);
  logic [1:0]       addrctl;
  logic [5:0]       opcode;
  logic             stall;
  logic [3:0]       state;
  logic             illegal_op;
  logic             fault;
  logic [5:0]       bad_opcode;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output addrctl, opcode, stall,
    input  state, illegal_op, fault, bad_opcode, instr_count, cycle_count
  );

  modport slave (
    input  addrctl, opcode, stall,
    output state, illegal_op, fault, bad_opcode, instr_count, cycle_count
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Next-microaddress sequencer: fetch/dispatch/increment selection, stall hold,
// illegal-opcode trapping and retired-instruction/cycle counters.
module microcode_sequencer #(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input logic                  clk,
  input logic                  reset,
  microcode_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    JEX     = 4'd9
  } ustate_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ustate_e          state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [5:0]       bad_q, bad_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic             miss;

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    fault_d   = fault_q;
    bad_d     = bad_q;
    icnt_d    = icnt_q;
    ccnt_d    = ccnt_q + ONE;
    miss      = 1'b0;
    if (!bus.stall) begin
      // Encodings 10-15 are unreachable in normal operation; trap them outright.
      if (state_q > JEX) begin
        miss = 1'b1;
      end else begin
        case (bus.addrctl)
          2'b00: begin
            state_d = FETCH;
            if (state_q != FETCH) icnt_d = icnt_q + ONE;
          end
          2'b01: begin
            if      (bus.opcode == OP_RTYPE) state_d = RTYPEEX;
            else if (bus.opcode == OP_LW)    state_d = MEMADR;
            else if (bus.opcode == OP_SW)    state_d = MEMADR;
            else if (bus.opcode == OP_BEQ)   state_d = BEQEX;
            else if (bus.opcode == OP_J)     state_d = JEX;
            else                             miss    = 1'b1;
          end
          2'b10: begin
            if      (bus.opcode == OP_LW) state_d = MEMRD;
            else if (bus.opcode == OP_SW) state_d = MEMWR;
            else                          miss    = 1'b1;
          end
          default: begin
            if (state_q == JEX) miss = 1'b1;
            else                state_d = ustate_e'(state_q + 4'd1);
          end
        endcase
      end
      if (miss) begin
        state_d   = FETCH;
        illegal_d = 1'b1;
        fault_d   = 1'b1;
        bad_d     = bus.opcode;
        icnt_d    = icnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      bad_q     <= 6'h00;
      icnt_q    <= '0;
      ccnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      bad_q     <= bad_d;
      icnt_q    <= icnt_d;
      ccnt_q    <= ccnt_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.fault       = fault_q;
  assign bus.bad_opcode  = bad_q;
  assign bus.instr_count = icnt_q;
  assign bus.cycle_count = ccnt_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer (CNT_W=4 so counter wrap is reachable);
// a reference model pushes expected outputs per step, popped one cycle later.
module tb_microcode_sequencer;
  localparam int CW = 4;

  typedef struct packed {
    logic [3:0]    st;
    logic          ill;
    logic          flt;
    logic [5:0]    bad;
    logic [CW-1:0] ic;
    logic [CW-1:0] cc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t mdl = '0;
  exp_t sbq[$];

  microcode_sequencer_if #(.CNT_W(CW)) vif();

  microcode_sequencer #(.CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mnext(exp_t cur, logic r, logic s, logic [1:0] ac, logic [5:0] op);
    exp_t n;
    logic ok;
    logic [3:0] tgt;
    if (r) return '0;
    n = cur;
    n.cc = cur.cc + 1'b1;
    n.ill = 1'b0;
    if (s) return n;
    ok = 1'b1;
    tgt = 4'd0;
    if (cur.st > 4'd9) ok = 1'b0;
    else if (ac == 2'b00) tgt = 4'd0;
    else if (ac == 2'b01) begin
      case (op)
        6'h00:        tgt = 4'd6;
        6'h23, 6'h2B: tgt = 4'd2;
        6'h04:        tgt = 4'd8;
        6'h02:        tgt = 4'd9;
        default:      ok = 1'b0;
      endcase
    end else if (ac == 2'b10) begin
      if (op == 6'h23)      tgt = 4'd3;
      else if (op == 6'h2B) tgt = 4'd5;
      else                  ok = 1'b0;
    end else begin
      ok = (cur.st < 4'd9);
      tgt = cur.st + 4'd1;
    end
    if (!ok) begin
      n.st = 4'd0; n.ill = 1'b1; n.flt = 1'b1; n.bad = op;
    end else begin
      n.st = tgt;
      if (ac == 2'b00 && cur.st != 4'd0) n.ic = cur.ic + 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [1:0] ac, input logic [5:0] op);
    exp_t e;
    reset = r;
    vif.stall = s;
    vif.addrctl = ac;
    vif.opcode = op;
    mdl = mnext(mdl, r, s, ac, op);
    sbq.push_back(mdl);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("state", 32'(vif.state), 32'(e.st));
    chk("illegal_op", 32'(vif.illegal_op), 32'(e.ill));
    chk("fault", 32'(vif.fault), 32'(e.flt));
    chk("bad_opcode", 32'(vif.bad_opcode), 32'(e.bad));
    chk("instr_count", 32'(vif.instr_count), 32'(e.ic));
    chk("cycle_count", 32'(vif.cycle_count), 32'(e.cc));
  endtask

  initial begin
    vif.stall = 1'b0;
    vif.addrctl = 2'b00;
    vif.opcode = 6'h00;

    step(1, 0, 2'b00, 6'h00);
    chk("rst_state", 32'(vif.state), 32'd0);
    chk("rst_cc", 32'(vif.cycle_count), 32'd0);
    step(0, 0, 2'b00, 6'h23);
    chk("fetch_hold_ic", 32'(vif.instr_count), 32'd0);

    // LW path through memory writeback
    step(0, 0, 2'b11, 6'h23);
    step(0, 0, 2'b01, 6'h23);
    chk("lw_disp1", 32'(vif.state), 32'd2);
    step(0, 0, 2'b10, 6'h23);
    chk("lw_disp2", 32'(vif.state), 32'd3);
    step(0, 0, 2'b11, 6'h23);
    chk("lw_wb", 32'(vif.state), 32'd4);
    step(0, 0, 2'b00, 6'h23);
    chk("lw_fetch", 32'(vif.state), 32'd0);
    chk("lw_ic", 32'(vif.instr_count), 32'd1);
    chk("lw_cc", 32'(vif.cycle_count), 32'd6);

    // SW with memory stall
    step(0, 0, 2'b11, 6'h2B);
    step(0, 0, 2'b01, 6'h2B);
    step(0, 0, 2'b10, 6'h2B);
    chk("sw_memwr", 32'(vif.state), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b00, 6'h2B);
      chk("stall_state", 32'(vif.state), 32'd5);
    end
    chk("stall_cc", 32'(vif.cycle_count), 32'd12);
    chk("stall_ic", 32'(vif.instr_count), 32'd1);
    step(0, 0, 2'b00, 6'h2B);
    chk("sw_ic", 32'(vif.instr_count), 32'd2);

    // illegal opcode on dispatch1
    step(0, 0, 2'b11, 6'h3F);
    step(0, 0, 2'b01, 6'h3F);
    chk("ill_state", 32'(vif.state), 32'd0);
    chk("ill_pulse", 32'(vif.illegal_op), 32'd1);
    chk("ill_fault", 32'(vif.fault), 32'd1);
    chk("ill_bad", 32'(vif.bad_opcode), 32'h3F);
    chk("ill_ic", 32'(vif.instr_count), 32'd2);
    step(0, 0, 2'b11, 6'h00);
    chk("ill_pulse_end", 32'(vif.illegal_op), 32'd0);
    chk("fault_sticky", 32'(vif.fault), 32'd1);

    // R-type, then BEQ into bad increment at JEX
    step(0, 0, 2'b01, 6'h00);
    chk("rtype_disp", 32'(vif.state), 32'd6);
    step(0, 0, 2'b11, 6'h00);
    step(0, 0, 2'b00, 6'h00);
    chk("rtype_ic", 32'(vif.instr_count), 32'd3);
    step(0, 0, 2'b11, 6'h04);
    step(0, 0, 2'b01, 6'h04);
    chk("beq_disp", 32'(vif.state), 32'd8);
    step(0, 0, 2'b11, 6'h04);
    chk("beq_incr", 32'(vif.state), 32'd9);
    step(0, 0, 2'b11, 6'h04);
    chk("badinc_state", 32'(vif.state), 32'd0);
    chk("badinc_pulse", 32'(vif.illegal_op), 32'd1);
    chk("badinc_bad", 32'(vif.bad_opcode), 32'h04);
    chk("badinc_ic", 32'(vif.instr_count), 32'd3);

    // reset mid-instruction during stall
    step(0, 0, 2'b11, 6'h00);
    step(0, 0, 2'b01, 6'h00);
    step(0, 0, 2'b11, 6'h00);
    step(0, 1, 2'b00, 6'h00);
    chk("pre_rst_state", 32'(vif.state), 32'd7);
    step(1, 1, 2'b11, 6'h00);
    chk("mid_rst_state", 32'(vif.state), 32'd0);
    chk("mid_rst_fault", 32'(vif.fault), 32'd0);
    chk("mid_rst_bad", 32'(vif.bad_opcode), 32'd0);
    chk("mid_rst_ic", 32'(vif.instr_count), 32'd0);
    chk("mid_rst_cc", 32'(vif.cycle_count), 32'd0);

    // instr_count wrap with jumps
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 2'b11, 6'h02);
      step(0, 0, 2'b01, 6'h02);
      step(0, 0, 2'b00, 6'h02);
    end
    chk("wrap_pre_ic", 32'(vif.instr_count), 32'd15);
    step(0, 0, 2'b11, 6'h02);
    step(0, 0, 2'b01, 6'h02);
    chk("j_disp", 32'(vif.state), 32'd9);
    step(0, 0, 2'b00, 6'h02);
    chk("wrap_ic", 32'(vif.instr_count), 32'd0);
    chk("wrap_fault", 32'(vif.fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
